// File: rtl/heartbeat_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_pulse_gen
// Brief    : Tick-timed lub-dub LED driver whose beat period follows a 2-bit rate code.
// Revision : 1.0
// ============================================================================
module heartbeat_pulse_gen #(
  parameter int unsigned LUB_T   = 2,
  parameter int unsigned GAP_T   = 2,
  parameter int unsigned DUB_T   = 1,
  parameter int unsigned PERIOD0 = 8,
  parameter int unsigned PERIOD1 = 16,
  parameter int unsigned PERIOD2 = 24,
  parameter int unsigned PERIOD3 = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] heartbeat,
  input  logic       tick,
  input  logic       en,
  output logic       led,
  output logic       beat,
  output logic [1:0] active_code,
  output logic [7:0] beat_cnt
);

  localparam int unsigned c_PMAX01 = (PERIOD0 > PERIOD1) ? PERIOD0 : PERIOD1;
  localparam int unsigned c_PMAX23 = (PERIOD2 > PERIOD3) ? PERIOD2 : PERIOD3;
  localparam int unsigned c_PMAX   = (c_PMAX01 > c_PMAX23) ? c_PMAX01 : c_PMAX23;
  localparam int          TCW      = $clog2(c_PMAX + 1);
  localparam int unsigned c_ACTIVE = LUB_T + GAP_T + DUB_T;

  // Terminal counts: a phase ends on the tick seen while tcnt holds its last value.
  localparam logic [TCW-1:0] c_LUB_LAST   = TCW'(LUB_T - 1);
  localparam logic [TCW-1:0] c_GAP_LAST   = TCW'(GAP_T - 1);
  localparam logic [TCW-1:0] c_DUB_LAST   = TCW'(DUB_T - 1);
  localparam logic [TCW-1:0] c_REST0_LAST = TCW'(PERIOD0 - c_ACTIVE - 1);
  localparam logic [TCW-1:0] c_REST1_LAST = TCW'(PERIOD1 - c_ACTIVE - 1);
  localparam logic [TCW-1:0] c_REST2_LAST = TCW'(PERIOD2 - c_ACTIVE - 1);
  localparam logic [TCW-1:0] c_REST3_LAST = TCW'(PERIOD3 - c_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LUB  = 3'd1,
    S_GAP  = 3'd2,
    S_DUB  = 3'd3,
    S_REST = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [TCW-1:0] r_tcnt;
  logic [TCW-1:0] w_tcnt_nxt;
  logic [TCW-1:0] w_rest_last;
  logic           w_enter_lub;
  logic [1:0]     r_active_code;
  logic [7:0]     r_beat_cnt;
  logic           r_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tcnt        <= '0;
      r_active_code <= 2'b11;
      r_beat_cnt    <= 8'd0;
      r_beat        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_beat  <= w_enter_lub;
      if (w_enter_lub) begin
        r_active_code <= heartbeat;
        r_beat_cnt    <= r_beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_enter_lub = 1'b0;
    w_rest_last = c_REST3_LAST;

    case (r_active_code)
      2'd0:    w_rest_last = c_REST0_LAST;
      2'd1:    w_rest_last = c_REST1_LAST;
      2'd2:    w_rest_last = c_REST2_LAST;
      default: w_rest_last = c_REST3_LAST;
    endcase

    if (tick) begin
      w_tcnt_nxt = r_tcnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          w_tcnt_nxt = '0;
          if (en) begin
            w_state_nxt = S_LUB;
            w_enter_lub = 1'b1;
          end
        end
        S_LUB: begin
          if (r_tcnt == c_LUB_LAST) begin
            w_state_nxt = S_GAP;
            w_tcnt_nxt  = '0;
          end
        end
        S_GAP: begin
          if (r_tcnt == c_GAP_LAST) begin
            w_state_nxt = S_DUB;
            w_tcnt_nxt  = '0;
          end
        end
        S_DUB: begin
          if (r_tcnt == c_DUB_LAST) begin
            w_state_nxt = S_REST;
            w_tcnt_nxt  = '0;
          end
        end
        S_REST: begin
          // en is only consulted here, so a dropped enable still finishes the beat.
          if (r_tcnt == w_rest_last) begin
            w_tcnt_nxt = '0;
            if (en) begin
              w_state_nxt = S_LUB;
              w_enter_lub = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign led         = (r_state == S_LUB) || (r_state == S_DUB);
  assign beat        = r_beat;
  assign active_code = r_active_code;
  assign beat_cnt    = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_heartbeat_pulse_gen
// Brief    : Randomized self-checking bench against a tick-position beat model.
// Revision : 1.0
// ============================================================================
module tb_heartbeat_pulse_gen;

  localparam int LUB = 2;
  localparam int GAP = 2;
  localparam int DUB = 1;
  localparam int P0  = 8;
  localparam int P1  = 16;
  localparam int P2  = 24;
  localparam int P3  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic [1:0] heartbeat = 2'd0;
  logic       led;
  logic       beat;
  logic [1:0] active_code;
  logic [7:0] beat_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int g_ticks  = 0;

  // Model: a beat is a position 0..period-1 measured in ticks from its start.
  bit         m_idle = 1'b1;
  int         m_pos  = 0;
  int         m_per  = 0;
  logic [1:0] m_code = 2'b11;
  logic [7:0] m_cnt  = 8'd0;
  logic       m_beat = 1'b0;

  heartbeat_pulse_gen #(
    .LUB_T(LUB), .GAP_T(GAP), .DUB_T(DUB),
    .PERIOD0(P0), .PERIOD1(P1), .PERIOD2(P2), .PERIOD3(P3)
  ) dut (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .tick(tick), .en(en),
    .led(led), .beat(beat), .active_code(active_code), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic int per_of(input logic [1:0] c);
    case (c)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  function automatic logic m_led();
    return !m_idle && ((m_pos < LUB) || ((m_pos >= LUB + GAP) && (m_pos < LUB + GAP + DUB)));
  endfunction

  function automatic logic [11:0] m_exp();
    return {m_led(), m_beat, m_code, m_cnt};
  endfunction

  task automatic m_start();
    m_idle = 1'b0;
    m_pos  = 0;
    m_code = heartbeat;
    m_per  = per_of(heartbeat);
    m_cnt  = m_cnt + 8'd1;
    m_beat = 1'b1;
  endtask

  // Advance the model with the inputs the DUT samples on the coming edge, then wait for the negedge.
  task automatic cyc();
    m_beat = 1'b0;
    if (tick) g_ticks++;
    if (rst) begin
      m_idle = 1'b1;
      m_pos  = 0;
      m_code = 2'b11;
      m_cnt  = 8'd0;
    end else if (tick) begin
      if (m_idle) begin
        if (en) m_start();
      end else begin
        m_pos++;
        if (m_pos == m_per) begin
          if (en) m_start();
          else m_idle = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; tick = 1'b1; heartbeat = 2'($urandom);
    cyc(); cyc(); cyc();
    n_checks++;
    if ({led, beat, active_code, beat_cnt} !== 12'h300) begin
      n_errors++; $display("FAIL reset_state got %h exp 300", {led, beat, active_code, beat_cnt});
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'($urandom_range(0, 1));
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL idle_no_en got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
    end
    en = 1'b1; tick = 1'b1; heartbeat = 2'd1;
    cyc();
    n_checks++;
    if ({beat, beat_cnt} !== {1'b1, 8'd1}) begin
      n_errors++; $display("FAIL first_beat got beat=%b cnt=%0d exp beat=1 cnt=1", beat, beat_cnt);
    end
  endtask

  task automatic test_rate1();
    int last = -1;
    int nb   = 0;
    int ledc = 0;
    do_reset();
    heartbeat = 2'd1; en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick = (i % 4 == 0);
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL rate1_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
      if (beat) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last != 64) begin
            n_errors++; $display("FAIL rate1_spacing got %0d clk exp 64", i - last);
          end
          n_checks++;
          if (ledc != 12) begin
            n_errors++; $display("FAIL rate1_led_clks got %0d exp 12", ledc);
          end
        end
        last = i; nb++; ledc = 0;
      end
      if (led) ledc++;
    end
    n_checks++;
    if (nb != 4) begin
      n_errors++; $display("FAIL rate1_beats got %0d exp 4", nb);
    end
  endtask

  task automatic test_rate_change();
    int nb = 0;
    int t_last = 0;
    bit sw = 1'b0;
    do_reset();
    heartbeat = 2'd3; en = 1'b1;
    for (int i = 0; i < 600 && nb < 4; i++) begin
      tick = 1'($urandom_range(0, 1));
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL rchg_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
      if (beat) begin
        nb++;
        if (nb == 1) begin
          n_checks++;
          if (active_code !== 2'd3) begin
            n_errors++; $display("FAIL rchg_code1 got %0d exp 3", active_code);
          end
        end else if (nb == 2) begin
          n_checks++;
          if (g_ticks - t_last != 32) begin
            n_errors++; $display("FAIL rchg_slow_beat got %0d ticks exp 32", g_ticks - t_last);
          end
          n_checks++;
          if (active_code !== 2'd0) begin
            n_errors++; $display("FAIL rchg_code2 got %0d exp 0", active_code);
          end
        end else begin
          n_checks++;
          if (g_ticks - t_last != 8) begin
            n_errors++; $display("FAIL rchg_fast_beat got %0d ticks exp 8", g_ticks - t_last);
          end
        end
        t_last = g_ticks;
      end
      if (nb == 1 && !sw && (g_ticks - t_last >= 12)) begin
        heartbeat = 2'd0; sw = 1'b1;
      end
    end
    n_checks++;
    if (nb != 4) begin
      n_errors++; $display("FAIL rchg_timeout got %0d beats exp 4", nb);
    end
  endtask

  task automatic test_same_edge();
    int t0;
    bit found = 1'b0;
    do_reset();
    heartbeat = 2'd3; en = 1'b1; tick = 1'b0;
    cyc(); cyc();
    heartbeat = 2'd2; tick = 1'b1;
    cyc();
    n_checks++;
    if ({beat, active_code} !== {1'b1, 2'd2}) begin
      n_errors++; $display("FAIL same_edge got beat=%b code=%0d exp beat=1 code=2", beat, active_code);
    end
    t0 = g_ticks;
    heartbeat = 2'd3;
    for (int i = 0; i < 300; i++) begin
      tick = 1'($urandom_range(0, 1));
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL same_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
      if (beat) begin
        found = 1'b1;
        n_checks++;
        if (g_ticks - t0 != 24) begin
          n_errors++; $display("FAIL same_len got %0d ticks exp 24", g_ticks - t0);
        end
        n_checks++;
        if (active_code !== 2'd3) begin
          n_errors++; $display("FAIL same_next_code got %0d exp 3", active_code);
        end
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL same_timeout got no beat exp beat within 300 clk");
    end
  endtask

  task automatic test_en_drop();
    int ledc;
    int nb = 0;
    do_reset();
    heartbeat = 2'd1; en = 1'b1; tick = 1'b1;
    cyc();
    ledc = int'(led);
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL endrop_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
      if (led) ledc++;
      if (beat) nb++;
    end
    n_checks++;
    if (ledc != LUB + DUB) begin
      n_errors++; $display("FAIL endrop_led got %0d exp %0d", ledc, LUB + DUB);
    end
    n_checks++;
    if (nb != 0 || beat_cnt !== 8'd1) begin
      n_errors++; $display("FAIL endrop_beats got extra=%0d cnt=%0d exp extra=0 cnt=1", nb, beat_cnt);
    end
  endtask

  task automatic test_wrap();
    int nb = 0;
    do_reset();
    heartbeat = 2'd0; en = 1'b1; tick = 1'b1;
    for (int i = 0; i < 256 * 8 + 40 && nb < 256; i++) begin
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL wrap_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
      if (beat) begin
        nb++;
        if (nb == 255) begin
          n_checks++;
          if (beat_cnt !== 8'd255) begin
            n_errors++; $display("FAIL wrap_255 got %0d exp 255", beat_cnt);
          end
        end else if (nb == 256) begin
          n_checks++;
          if (beat_cnt !== 8'd0) begin
            n_errors++; $display("FAIL wrap_0 got %0d exp 0", beat_cnt);
          end
        end
      end
    end
    n_checks++;
    if (nb != 256) begin
      n_errors++; $display("FAIL wrap_timeout got %0d beats exp 256", nb);
    end
  endtask

  task automatic test_rst_dub();
    do_reset();
    heartbeat = 2'd1; en = 1'b1; tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!m_idle && m_pos == LUB + GAP) break;
    end
    n_checks++;
    if (led !== 1'b1) begin
      n_errors++; $display("FAIL rstdub_in_dub got led=%b exp 1", led);
    end
    rst = 1'b1; tick = 1'b1;
    cyc();
    n_checks++;
    if ({led, beat, active_code, beat_cnt} !== 12'h300) begin
      n_errors++; $display("FAIL rstdub_state got %h exp 300", {led, beat, active_code, beat_cnt});
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if ({led, beat, beat_cnt} !== 10'h000) begin
        n_errors++; $display("FAIL rstdub_idle got %h exp 000", {led, beat, beat_cnt});
      end
    end
    en = 1'b1;
    cyc();
    n_checks++;
    if ({beat, beat_cnt} !== {1'b1, 8'd1}) begin
      n_errors++; $display("FAIL rstdub_restart got beat=%b cnt=%0d exp beat=1 cnt=1", beat, beat_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 9) != 0);
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) heartbeat = 2'($urandom);
      cyc();
      n_checks++;
      if ({led, beat, active_code, beat_cnt} !== m_exp()) begin
        n_errors++; $display("FAIL random_model got %h exp %h", {led, beat, active_code, beat_cnt}, m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rate1();
    test_rate_change();
    test_same_edge();
    test_en_drop();
    test_wrap();
    test_rst_dub();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
